// File: rtl/keypad_pkg.sv
// Shared constants for the keypad scanner: event type codes, FSM state
// encoding and a width helper used throughout the scanner and its FIFO.
package keypad_pkg;

   localparam logic [1:0] EVT_PRESS   = 2'b01;
   localparam logic [1:0] EVT_RELEASE = 2'b10;
   localparam logic [1:0] EVT_REPEAT  = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HELD    = 2'd1,
      LOCKOUT = 2'd2
   } kp_state_t;

   // Ceiling log2, never below 1 so it can always size a vector.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Key-event stream between the scanner (master) and the downstream
// controller (slave): valid/ready handshake carrying a code and an event type.
interface keypad_evt_if #(
   parameter int CODE_W = 4
);
   logic              evt_valid;
   logic              evt_ready;
   logic [CODE_W-1:0] evt_code;
   logic [1:0]        evt_type;

   modport master (output evt_valid, output evt_code, output evt_type, input evt_ready);
   modport slave  (input evt_valid, input evt_code, input evt_type, output evt_ready);
endinterface

// File: rtl/keypad_evt_fifo.sv
// Small synchronous event FIFO; a push into a full queue with no
// simultaneous pop is dropped and latches the sticky overflow flag.
module keypad_evt_fifo
   import keypad_pkg::*;
#(
   parameter int WIDTH = 6,
   parameter int DEPTH = 4
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             overflow,
   input  logic             clr_ovf
);
   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic             overflow_reg;
   logic             full;
   logic             pop_ok;
   logic             push_ok;

   // Extra pointer bit distinguishes full from empty when the addresses match.
   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (push && full && !pop_ok) overflow_reg <= 1'b1;
         else if (clr_ovf)            overflow_reg <= 1'b0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (push_ok) mem[wr_ptr_reg[AW-1:0]] <= push_data;
   end

   assign head     = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
   assign overflow = overflow_reg;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Matrix keypad scanner: one-hot row drive, whole-frame debounce,
// press/hold/release FSM with optional auto-repeat, and a queued event output.
module keypad_matrix_scanner
   import keypad_pkg::*;
#(
   parameter  int ROWS         = 4,
   parameter  int COLS         = 3,
   parameter  int SCAN_DIV     = 1000,
   parameter  int DEBOUNCE     = 3,
   parameter  int REPEAT_SCANS = 0,
   parameter  int FIFO_DEPTH   = 4,
   localparam int CODE_W       = clog2(ROWS * COLS)
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic [COLS-1:0]   col_in,
   output logic [ROWS-1:0]   row_out,
   keypad_evt_if.master      evt,
   output logic              key_down,
   output logic [CODE_W-1:0] held_code,
   output logic              overflow,
   input  logic              clr_ovf
);
   localparam int NKEYS = ROWS * COLS;
   localparam int DIV_W = clog2(SCAN_DIV);
   localparam int ROW_W = clog2(ROWS);
   localparam int DEB_W = clog2(DEBOUNCE + 1);
   localparam int REP_W = clog2(REPEAT_SCANS + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
   localparam logic [DEB_W-1:0] DEB_FULL = DEB_W'(DEBOUNCE);
   localparam logic [DEB_W-1:0] DEB_PRE  = DEB_W'(DEBOUNCE - 1);
   localparam logic [REP_W-1:0] REP_LAST = (REPEAT_SCANS > 0) ? REP_W'(REPEAT_SCANS - 1) : '0;

   logic [DIV_W-1:0]  div_cnt_reg;
   logic [ROW_W-1:0]  row_idx_reg;
   logic [ROWS-1:0]   row_onehot_reg;
   logic [NKEYS-1:0]  frame_reg;
   logic [NKEYS-1:0]  prev_frame_reg;
   logic [NKEYS-1:0]  frame_now;
   logic [DEB_W-1:0]  stable_cnt_reg;
   logic              tick;
   logic              last_row;
   logic              frame_end;
   logic              frame_same;
   logic              commit;
   logic              scan_pulse;

   assign tick       = (div_cnt_reg == DIV_LAST);
   assign last_row   = (row_idx_reg == ROW_LAST);
   assign frame_end  = tick && last_row;
   assign frame_same = (frame_now == prev_frame_reg);
   assign commit     = frame_end && (frame_same ? (stable_cnt_reg == DEB_PRE) : (DEBOUNCE == 1));
   assign scan_pulse = frame_end && frame_same && (stable_cnt_reg == DEB_FULL);
   assign row_out    = row_onehot_reg;

   // The row currently driven sees live columns so the frame is complete at frame end.
   for (genvar gi = 0; gi < ROWS; gi++) begin : g_frame
      assign frame_now[gi*COLS +: COLS] = (row_idx_reg == ROW_W'(gi)) ? col_in
                                                                      : frame_reg[gi*COLS +: COLS];
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         div_cnt_reg    <= '0;
         row_idx_reg    <= '0;
         row_onehot_reg <= ROWS'(1);
         frame_reg      <= '0;
         prev_frame_reg <= '0;
         stable_cnt_reg <= '0;
      end else if (tick) begin
         div_cnt_reg    <= '0;
         row_idx_reg    <= last_row ? '0 : row_idx_reg + 1'b1;
         row_onehot_reg <= {row_onehot_reg[ROWS-2:0], row_onehot_reg[ROWS-1]};
         frame_reg      <= frame_now;
         if (last_row) begin
            if (frame_same) begin
               if (stable_cnt_reg != DEB_FULL) stable_cnt_reg <= stable_cnt_reg + 1'b1;
            end else begin
               stable_cnt_reg <= DEB_W'(1);
               prev_frame_reg <= frame_now;
            end
         end
      end else begin
         div_cnt_reg <= div_cnt_reg + 1'b1;
      end
   end

   logic              one_seen;
   logic              multi;
   logic              single;
   logic [CODE_W-1:0] single_code;

   always_comb begin
      one_seen    = 1'b0;
      multi       = 1'b0;
      single_code = '0;
      for (int i = 0; i < NKEYS; i++) begin
         if (frame_now[i]) begin
            if (one_seen) multi = 1'b1;
            one_seen    = 1'b1;
            single_code = CODE_W'(i);
         end
      end
   end
   assign single = one_seen && !multi;

   kp_state_t         state_reg, state_next;
   logic [CODE_W-1:0] held_code_reg, held_code_next;
   logic [REP_W-1:0]  rep_cnt_reg, rep_cnt_next;
   logic              push_reg, push_next;
   logic [CODE_W-1:0] push_code_reg, push_code_next;
   logic [1:0]        push_type_reg, push_type_next;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg     <= IDLE;
         held_code_reg <= '0;
         rep_cnt_reg   <= '0;
         push_reg      <= 1'b0;
         push_code_reg <= '0;
         push_type_reg <= EVT_PRESS;
      end else begin
         state_reg     <= state_next;
         held_code_reg <= held_code_next;
         rep_cnt_reg   <= rep_cnt_next;
         push_reg      <= push_next;
         push_code_reg <= push_code_next;
         push_type_reg <= push_type_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      held_code_next = held_code_reg;
      rep_cnt_next   = rep_cnt_reg;
      push_next      = 1'b0;
      push_code_next = held_code_reg;
      push_type_next = EVT_PRESS;
      case (state_reg)
         IDLE: begin
            if (commit && single) begin
               push_next      = 1'b1;
               push_code_next = single_code;
               held_code_next = single_code;
               rep_cnt_next   = '0;
               state_next     = HELD;
            end
         end
         HELD: begin
            if (commit) begin
               if (!one_seen) begin
                  push_next      = 1'b1;
                  push_type_next = EVT_RELEASE;
                  state_next     = IDLE;
               end else if (multi || single_code != held_code_reg) begin
                  // A different or ghosted pattern ends the hold; wait for all keys up.
                  push_next      = 1'b1;
                  push_type_next = EVT_RELEASE;
                  state_next     = LOCKOUT;
               end
            end else if (scan_pulse && REPEAT_SCANS > 0) begin
               if (rep_cnt_reg == REP_LAST) begin
                  push_next      = 1'b1;
                  push_type_next = EVT_REPEAT;
                  rep_cnt_next   = '0;
               end else begin
                  rep_cnt_next = rep_cnt_reg + 1'b1;
               end
            end
         end
         LOCKOUT: begin
            if (commit && !one_seen) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign key_down  = (state_reg == HELD);
   assign held_code = held_code_reg;

   logic fifo_empty;

   keypad_evt_fifo #(
      .WIDTH (CODE_W + 2),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .push      (push_reg),
      .push_data ({push_type_reg, push_code_reg}),
      .pop       (evt.evt_ready),
      .head      ({evt.evt_type, evt.evt_code}),
      .empty     (fifo_empty),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   assign evt.evt_valid = !fifo_empty;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboarded bench: two scanners (repeat off / repeat every 3 scans) driven
// by a modelled 4x3 key matrix; monitors compare popped events to queued expectations.
module tb_keypad_matrix_scanner;
   import keypad_pkg::*;

   logic        clk = 1'b0;
   logic        rst_a_n, rst_b_n;
   logic [11:0] keys_a, keys_b;
   logic [2:0]  col_a, col_b;
   logic [3:0]  row_a, row_b;
   logic        kd_a, kd_b;
   logic [3:0]  held_a, held_b;
   logic        ovf_a, ovf_b, clr_a, clr_b;

   logic [5:0]  sb_a[$];
   logic [5:0]  sb_b[$];
   int          pass_cnt = 0;
   int          total_cnt = 0;

   keypad_evt_if #(.CODE_W(4)) ev_a();
   keypad_evt_if #(.CODE_W(4)) ev_b();

   always #5 clk = ~clk;

   // Matrix model: a pressed key connects its row to its column.
   always_comb begin
      col_a = '0;
      col_b = '0;
      for (int r = 0; r < 4; r++) begin
         if (row_a[r]) col_a = col_a | keys_a[r*3 +: 3];
         if (row_b[r]) col_b = col_b | keys_b[r*3 +: 3];
      end
   end

   keypad_matrix_scanner #(.ROWS(4), .COLS(3), .SCAN_DIV(4), .DEBOUNCE(2),
                           .REPEAT_SCANS(0), .FIFO_DEPTH(4)) dut_a (
      .sys_clk(clk), .sys_rst_n(rst_a_n), .col_in(col_a), .row_out(row_a), .evt(ev_a),
      .key_down(kd_a), .held_code(held_a), .overflow(ovf_a), .clr_ovf(clr_a));

   keypad_matrix_scanner #(.ROWS(4), .COLS(3), .SCAN_DIV(4), .DEBOUNCE(2),
                           .REPEAT_SCANS(3), .FIFO_DEPTH(4)) dut_b (
      .sys_clk(clk), .sys_rst_n(rst_b_n), .col_in(col_b), .row_out(row_b), .evt(ev_b),
      .key_down(kd_b), .held_code(held_b), .overflow(ovf_b), .clr_ovf(clr_b));

   function automatic logic [5:0] ev(input logic [1:0] t, input int code);
      return {t, 4'(code)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (rst_a_n && ev_a.evt_valid && ev_a.evt_ready) begin
         $display("evt a: type=%0d code=%0d", ev_a.evt_type, ev_a.evt_code);
         if (sb_a.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_evt_a actual=%0h required=none", {ev_a.evt_type, ev_a.evt_code});
         end else check("evt_a", {ev_a.evt_type, ev_a.evt_code}, sb_a.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst_b_n && ev_b.evt_valid && ev_b.evt_ready) begin
         $display("evt b: type=%0d code=%0d", ev_b.evt_type, ev_b.evt_code);
         if (sb_b.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_evt_b actual=%0h required=none", {ev_b.evt_type, ev_b.evt_code});
         end else check("evt_b", {ev_b.evt_type, ev_b.evt_code}, sb_b.pop_front());
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Advance to the start of the next scan (row 0 freshly driven), bounded.
   task automatic next_scan();
      int n = 0;
      while (row_a != 4'b1000 && n < 100) begin cycles(1); n++; end
      while (row_a != 4'b0001 && n < 100) begin cycles(1); n++; end
      if (n >= 100) begin
         total_cnt++;
         $display("FAIL scan_timeout actual=%0d required=<100", n);
      end
   endtask

   task automatic hold_a(input logic [11:0] k, input int n);
      keys_a = k;
      repeat (n) next_scan();
   endtask

   task automatic check_reset(input string tag, input logic [3:0] row, input logic vld,
                              input logic [3:0] code, input logic [1:0] typ, input logic kd,
                              input logic [3:0] held, input logic ovf);
      check({tag, "_row"}, row, 4'b0001);
      check({tag, "_valid"}, vld, 1'b0);
      check({tag, "_code"}, code, 4'd0);
      check({tag, "_type"}, typ, 2'd0);
      check({tag, "_key_down"}, kd, 1'b0);
      check({tag, "_held"}, held, 4'd0);
      check({tag, "_overflow"}, ovf, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_a_n = 1'b0; rst_b_n = 1'b0;
      keys_a = '0; keys_b = '0;
      clr_a = 1'b0; clr_b = 1'b0;
      ev_a.evt_ready = 1'b1; ev_b.evt_ready = 1'b1;
      cycles(3);
      check_reset("rst_a", row_a, ev_a.evt_valid, ev_a.evt_code, ev_a.evt_type, kd_a, held_a, ovf_a);
      rst_a_n = 1'b1; rst_b_n = 1'b1;

      // 1: row rotation, four clocks per row, no events with idle matrix
      for (int k = 0; k <= 16; k++) begin
         if (k > 0) cycles(1);
         check($sformatf("row_seq_%0d", k), row_a, 4'b0001 << ((k / 4) % 4));
      end

      // 2: key 5 press then release
      next_scan();
      sb_a.push_back(ev(EVT_PRESS, 5));
      hold_a(12'd1 << 5, 3);
      check("press5_key_down", kd_a, 1'b1);
      check("press5_held", held_a, 4'd5);
      sb_a.push_back(ev(EVT_RELEASE, 5));
      hold_a(12'd0, 3);
      check("rel5_key_down", kd_a, 1'b0);
      check("rel5_held_kept", held_a, 4'd5);
      check("s2_drained", sb_a.size(), 0);

      // 3: bounce on alternate scans, then stable press of key 9
      for (int i = 0; i < 4; i++) hold_a((i % 2 == 0) ? (12'd1 << 9) : 12'd0, 1);
      check("bounce_no_evt", sb_a.size(), 0);
      sb_a.push_back(ev(EVT_PRESS, 9));
      hold_a(12'd1 << 9, 3);
      sb_a.push_back(ev(EVT_RELEASE, 9));
      hold_a(12'd0, 3);
      check("s3_drained", sb_a.size(), 0);

      // 4: ghosting from IDLE, then lockout after a second key joins
      hold_a((12'd1 << 0) | (12'd1 << 4), 3);
      check("ghost_key_down", kd_a, 1'b0);
      hold_a(12'd0, 3);
      sb_a.push_back(ev(EVT_PRESS, 7));
      hold_a(12'd1 << 7, 3);
      sb_a.push_back(ev(EVT_RELEASE, 7));
      hold_a((12'd1 << 7) | (12'd1 << 8), 3);
      check("lockout_key_down", kd_a, 1'b0);
      hold_a(12'd1 << 7, 3);
      check("lockout_single_ignored", kd_a, 1'b0);
      hold_a(12'd0, 3);
      sb_a.push_back(ev(EVT_PRESS, 3));
      hold_a(12'd1 << 3, 3);
      sb_a.push_back(ev(EVT_RELEASE, 3));
      hold_a(12'd0, 3);
      check("s4_drained", sb_a.size(), 0);

      // 5: backpressure, fifth event dropped, drain in order, clear overflow
      ev_a.evt_ready = 1'b0;
      sb_a.push_back(ev(EVT_PRESS, 1));
      hold_a(12'd1 << 1, 3);
      check("bp_valid", ev_a.evt_valid, 1'b1);
      check("bp_head1", {ev_a.evt_type, ev_a.evt_code}, ev(EVT_PRESS, 1));
      sb_a.push_back(ev(EVT_RELEASE, 1));
      hold_a(12'd0, 3);
      sb_a.push_back(ev(EVT_PRESS, 2));
      hold_a(12'd1 << 2, 3);
      sb_a.push_back(ev(EVT_RELEASE, 2));
      hold_a(12'd0, 3);
      check("bp_no_ovf_at_4", ovf_a, 1'b0);
      check("bp_head4", {ev_a.evt_type, ev_a.evt_code}, ev(EVT_PRESS, 1));
      hold_a(12'd1 << 6, 3);
      check("bp_ovf", ovf_a, 1'b1);
      check("bp_head5", {ev_a.evt_type, ev_a.evt_code}, ev(EVT_PRESS, 1));
      ev_a.evt_ready = 1'b1;
      cycles(8);
      check("bp_drained", sb_a.size(), 0);
      check("bp_empty", ev_a.evt_valid, 1'b0);
      check("bp_ovf_sticky", ovf_a, 1'b1);
      clr_a = 1'b1;
      cycles(1);
      clr_a = 1'b0;
      check("bp_ovf_cleared", ovf_a, 1'b0);
      next_scan();
      sb_a.push_back(ev(EVT_RELEASE, 6));
      hold_a(12'd0, 3);
      check("s5_drained", sb_a.size(), 0);

      // 6: auto-repeat every 3 scans on dut_b, then reset mid-hold
      sb_b.push_back(ev(EVT_PRESS, 11));
      sb_b.push_back(ev(EVT_REPEAT, 11));
      sb_b.push_back(ev(EVT_REPEAT, 11));
      keys_b = 12'd1 << 11;
      repeat (4) next_scan();
      cycles(4);
      check("rep_after_press", sb_b.size(), 2);
      check("rep_key_down", kd_b, 1'b1);
      check("rep_held", held_b, 4'd11);
      next_scan();
      cycles(4);
      check("rep_first", sb_b.size(), 1);
      repeat (3) next_scan();
      cycles(4);
      check("rep_second", sb_b.size(), 0);
      cycles(3);
      rst_b_n = 1'b0;
      #1;
      check_reset("rst_b", row_b, ev_b.evt_valid, ev_b.evt_code, ev_b.evt_type, kd_b, held_b, ovf_b);
      keys_b = '0;
      cycles(2);
      rst_b_n = 1'b1;
      cycles(1);
      check("rst_b_valid_after", ev_b.evt_valid, 1'b0);
      repeat (3) next_scan();
      check("s6_no_release", sb_b.size(), 0);
      check("s6_a_quiet", sb_a.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
